// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op-type encodings, widths and execution-unit state enum
package alu_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one-bit-per-cycle logical shifter holding accumulator, count and direction
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_dir_right,
  input  logic [DATA_W-1:0] i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0] o_acc_next,
  output logic              o_last
);

  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;

  assign o_acc_next = dir_q ? (acc_q >> 1) : (acc_q << 1);
  // The step taken while the count reads one produces the final value.
  assign o_last     = (cnt_q == SHAMT_W'(1));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (i_load) begin
      acc_d = i_a;
      cnt_d = i_shamt;
      dir_d = i_dir_right;
    end else if (i_step) begin
      acc_d = o_acc_next;
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execution-stage ALU with single-cycle logic/arith and iterative shifts
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_ALU_Optype,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_illegal
);

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  logic              sh_load, sh_step, sh_last;
  logic [DATA_W-1:0] sh_acc_next;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = i_B[SHAMT_W-1:0];

  alu_iter_shifter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (sh_load),
    .i_step     (sh_step),
    .i_dir_right(i_ALU_Optype == ALU_SRL),
    .i_a        (i_A),
    .i_shamt    (shamt),
    .o_acc_next (sh_acc_next),
    .o_last     (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          illegal_d = 1'b0;
          state_d   = ST_DONE;
          case (i_ALU_Optype)
            ALU_AND: result_d = i_A & i_B;
            ALU_OR:  result_d = i_A | i_B;
            ALU_ADD: result_d = i_A + i_B;
            ALU_XOR: result_d = i_A ^ i_B;
            ALU_SUB: result_d = i_A - i_B;
            ALU_SLL, ALU_SRL: begin
              if (shamt == '0) begin
                result_d = i_A;
              end else begin
                sh_load = 1'b1;
                state_d = ST_SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d = sh_acc_next;
          zero_d   = (sh_acc_next == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Draining costs a cycle in IDLE before the next accept.
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_valid   = (state_q == ST_DONE);
  assign o_result  = result_q;
  assign o_zero    = zero_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with randomized ops and a reference model
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          t;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_ALU_Optype = 4'd0;
  logic [63:0] i_A = '0;
  logic [63:0] i_B = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [63:0] o_result;
  logic        o_zero;
  logic        o_illegal;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  exp_t q[$];

  alu_exec_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ALU_Optype(i_ALU_Optype),
    .i_A         (i_A),
    .i_B         (i_B),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_zero      (o_zero),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ($urandom_range(3) != 0);
      default: i_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: direct arithmetic on the op rules, latency counted in cycles from accept.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[5:0]);
    e.ill = 1'b0;
    e.lat = 1;
    e.t   = 0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = a + b;
      4'd3: e.res = a ^ b;
      4'd6: e.res = a - b;
      4'd4: begin e.res = a << sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd5: begin e.res = a >> sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      default: begin e.res = 64'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, output int t_acc);
    exp_t e;
    bit   accepted;
    e = model(op, a, b);
    accepted = 0;
    t_acc = -1;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_ALU_Optype = op;
    i_A = a;
    i_B = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        e.t = cyc;
        t_acc = cyc;
        q.push_back(e);
        accepted = 1;
        break;
      end
    end
    if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_ALU_Optype = 4'($urandom);
    i_A = {$urandom, $urandom};
    i_B = {$urandom, $urandom};
  endtask

  task automatic wait_empty();
    bit done;
    done = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge i_clk);
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares each presented result against the head of the scoreboard.
  bit          prev_valid = 0;
  bit          drained = 0;
  logic [63:0] held;
  exp_t        cur;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (drained) begin
        chk("ready_after_drain", 64'(o_ready), 64'd1);
        chk("valid_after_drain", 64'(o_valid), 64'd0);
        drained = 0;
      end
      if (o_valid) begin
        chk("ready_low_while_valid", 64'(o_ready), 64'd0);
        if (!prev_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
          end else begin
            cur = q[0];
            chk("latency", 64'(cyc - cur.t), 64'(cur.lat));
            chk("result", o_result, cur.res);
            chk("zero", 64'(o_zero), 64'(cur.zero));
            chk("illegal", 64'(o_illegal), 64'(cur.ill));
          end
          held = o_result;
        end else begin
          chk("result_stable", o_result, held);
        end
        if (i_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          drained = 1;
        end
      end
      prev_valid = o_valid;
    end else begin
      prev_valid = 0;
      drained = 0;
    end
  end

  initial begin
    int t;
    int ok;
    logic [3:0] op;
    logic [63:0] a;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_zero", 64'(o_zero), 64'd0);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    ready_mode = 0;
    issue(ALU_ADD, 64'd5, 64'd7, t);
    issue(ALU_SUB, 64'd9, 64'd9, t);
    issue(ALU_SUB, 64'd0, 64'd1, t);
    issue(ALU_SLL, 64'd1, 64'd63, t);
    issue(ALU_SRL, 64'h80, 64'h107, t);
    issue(4'b1111, 64'h1234, 64'h5678, t);
    a = {$urandom, $urandom};
    issue(ALU_SLL, a, 64'h40, t);
    issue(ALU_SRL, a, 64'h0, t);
    wait_empty();

    // Backpressure: hold the result while offering a new op that must be ignored.
    ready_mode = 2;
    issue(ALU_XOR, 64'hF0, 64'hFF, t);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("xor_valid_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      i_ALU_Optype = ALU_ADD;
      i_A = 64'd100;
      i_B = 64'd200;
    end
    @(negedge i_clk);
    chk("hold_valid", 64'(o_valid), 64'd1);
    chk("hold_result", o_result, 64'h0F);
    i_valid = 1'b0;
    ready_mode = 0;
    wait_empty();

    // Reset in the middle of a long shift discards it.
    issue(ALU_SLL, 64'd1, 64'd40, t);
    while (cyc < t + 10) begin
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("midshift_rst_valid", 64'(o_valid), 64'd0);
    chk("midshift_rst_result", o_result, 64'd0);
    chk("midshift_rst_ready", 64'(o_ready), 64'd1);
    q.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    issue(ALU_ADD, 64'd2, 64'd2, t);
    wait_empty();

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 7)) : 4'($urandom_range(6));
      a = {$urandom, $urandom};
      if ($urandom_range(3) == 0) a = '0;
      issue(op, a, {$urandom, $urandom}, t);
    end
    wait_empty();
    ready_mode = 0;
    repeat (2) @(posedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
